// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the multicycle ALU.
//   alu_op_e     - 4-bit ALUControl opcode encoding
//   alu_state_e  - handshake FSM states
//   md_op_e      - operation selector for the iterative mul/div engine
//   is_iterative - true for opcodes that normally run on the mul/div engine
package alu_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [3:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLT   = 4'b0101,
      OP_SLTU  = 4'b0110,
      OP_SLL   = 4'b0111,
      OP_SRL   = 4'b1000,
      OP_SRA   = 4'b1001,
      OP_MUL   = 4'b1010,
      OP_MULHU = 4'b1011,
      OP_DIVU  = 4'b1100,
      OP_REMU  = 4'b1101,
      OP_DIV   = 4'b1110,
      OP_REM   = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } alu_state_e;

   typedef enum logic {
      MD_MUL = 1'b0,
      MD_DIV = 1'b1
   } md_op_e;

   // Multiply/divide family; special-case divides are filtered out by the top.
   function automatic logic is_iterative(alu_op_e op);
      case (op)
         OP_MUL, OP_MULHU, OP_DIVU, OP_REMU, OP_DIV, OP_REM: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// alu_multicycle_if: request/response bundle between the core and the ALU.
//   in_valid/in_ready   - request handshake (requester -> ALU)
//   a, b, ALUControl    - operands and opcode, captured on accept
//   out_valid/out_ready - result handshake (ALU -> consumer)
//   y, Zero             - registered result and its zero flag
interface alu_multicycle_if #(parameter int XLEN = alu_pkg::XLEN_DEFAULT);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [3:0]      ALUControl;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] y;
   logic            Zero;

   modport master (
      output in_valid, a, b, ALUControl, out_ready,
      input  in_ready, out_valid, y, Zero
   );

   modport slave (
      input  in_valid, a, b, ALUControl, out_ready,
      output in_ready, out_valid, y, Zero
   );
endinterface

// File: rtl/muldiv_iter.sv
// muldiv_iter: XLEN-step unsigned engine, shift-add multiply or restoring
// divide, one step per clock, both sharing a single iteration counter.
//   clk, reset - clock and synchronous active-high reset
//   start      - load operands and begin (ignored unless pulsed by the top)
//   op         - MD_MUL or MD_DIV
//   opa, opb   - unsigned operands (multiplicand/multiplier, dividend/divisor)
//   done       - high during the final step; results valid in that same cycle
//   res_hi     - product high half, or remainder
//   res_lo     - product low half, or quotient
module muldiv_iter
   import alu_pkg::*;
#(parameter int XLEN = XLEN_DEFAULT)
(
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  md_op_e          op,
   input  logic [XLEN-1:0] opa,
   input  logic [XLEN-1:0] opb,
   output logic            done,
   output logic [XLEN-1:0] res_hi,
   output logic [XLEN-1:0] res_lo
);
   localparam int CW = $clog2(XLEN);

   md_op_e          op_q;
   logic            running;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] hi;
   logic [XLEN-1:0] lo;
   logic [XLEN-1:0] dvs;
   logic [XLEN-1:0] next_hi;
   logic [XLEN-1:0] next_lo;
   logic [XLEN:0]   sum;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // One step of the selected algorithm. {hi,lo} is the multiply accumulator
   // (multiplier shifts out of lo as the product shifts in) or the
   // remainder/quotient pair (dividend shifts out of lo as quotient bits enter).
   // The XLEN+1-bit trial difference cannot overflow because hi < divisor.
   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      next_hi = hi;
      next_lo = lo;
      if (op_q == MD_MUL) begin
         sum     = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
         next_hi = sum[XLEN:1];
         next_lo = {sum[0], lo[XLEN-1:1]};
      end else begin
         shifted = {hi, lo[XLEN-1]};
         diff    = shifted - {1'b0, dvs};
         if (!diff[XLEN]) begin
            next_hi = diff[XLEN-1:0];
            next_lo = {lo[XLEN-2:0], 1'b1};
         end else begin
            next_hi = shifted[XLEN-1:0];
            next_lo = {lo[XLEN-2:0], 1'b0};
         end
      end
   end

   // Operand load on start, then XLEN steps counting down to zero. The last
   // step's result is exposed combinationally so the top can register it on
   // the same edge that ends the operation.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q    <= MD_MUL;
         running <= 1'b0;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         dvs     <= '0;
      end else if (start) begin
         op_q    <= op;
         running <= 1'b1;
         cnt     <= CW'(XLEN - 1);
         hi      <= '0;
         lo      <= (op == MD_MUL) ? opb : opa;
         dvs     <= (op == MD_MUL) ? opa : opb;
      end else if (running) begin
         hi <= next_hi;
         lo <= next_lo;
         if (cnt == '0) begin
            running <= 1'b0;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

   assign done   = running && (cnt == '0);
   assign res_hi = next_hi;
   assign res_lo = next_lo;

endmodule

// File: rtl/alu_multicycle.sv
// alu_multicycle: RV32I/M execution unit behind a valid/ready handshake.
// Simple ops and degenerate divides finish in one cycle; multiply/divide run
// XLEN steps on muldiv_iter. Signed divide works on magnitudes and fixes
// the signs afterwards.
//   clk, reset - clock and synchronous active-high reset
//   bus        - alu_multicycle_if slave: request, operands, opcode, result
module alu_multicycle
   import alu_pkg::*;
#(parameter int XLEN = XLEN_DEFAULT)
(
   input  logic            clk,
   input  logic            reset,
   alu_multicycle_if.slave bus
);
   localparam int              SHW     = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   alu_state_e      state;
   alu_state_e      next_state;
   alu_op_e         op_in;
   alu_op_e         op_q;
   logic            q_neg;
   logic            r_neg;
   logic            in_ready;
   logic            accept;
   logic            special;
   logic            iter_go;
   logic            signed_op;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic [XLEN-1:0] fast_res;
   logic [XLEN-1:0] iter_res;
   logic [XLEN-1:0] y_q;
   logic            zero_q;
   md_op_e          md_op;
   logic            md_done;
   logic [XLEN-1:0] md_hi;
   logic [XLEN-1:0] md_lo;

   // Single-cycle results, including the divide cases that need no
   // iteration (divide by zero and most-negative / -1 overflow).
   always_comb begin
      op_in     = alu_op_e'(bus.ALUControl);
      shamt     = bus.b[SHW-1:0];
      signed_op = (op_in == OP_DIV) || (op_in == OP_REM);
      mag_a     = (signed_op && bus.a[XLEN-1]) ? -bus.a : bus.a;
      mag_b     = (signed_op && bus.b[XLEN-1]) ? -bus.b : bus.b;
      md_op     = (op_in == OP_MUL || op_in == OP_MULHU) ? MD_MUL : MD_DIV;
      special   = 1'b0;
      fast_res  = '0;
      case (op_in)
         OP_ADD:   fast_res = bus.a + bus.b;
         OP_SUB:   fast_res = bus.a - bus.b;
         OP_AND:   fast_res = bus.a & bus.b;
         OP_OR:    fast_res = bus.a | bus.b;
         OP_XOR:   fast_res = bus.a ^ bus.b;
         OP_SLT:   fast_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         OP_SLTU:  fast_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
         OP_SLL:   fast_res = bus.a << shamt;
         OP_SRL:   fast_res = bus.a >> shamt;
         OP_SRA:   fast_res = $unsigned($signed(bus.a) >>> shamt);
         OP_MUL, OP_MULHU: fast_res = '0;
         OP_DIVU, OP_DIV: begin
            if (bus.b == '0) begin
               special  = 1'b1;
               fast_res = '1;
            end else if (op_in == OP_DIV && bus.a == MIN_NEG && bus.b == '1) begin
               special  = 1'b1;
               fast_res = bus.a;
            end
         end
         OP_REMU, OP_REM: begin
            if (bus.b == '0) begin
               special  = 1'b1;
               fast_res = bus.a;
            end else if (op_in == OP_REM && bus.a == MIN_NEG && bus.b == '1) begin
               special  = 1'b1;
               fast_res = '0;
            end
         end
         default: fast_res = '0;
      endcase
      iter_go = is_iterative(op_in) && !special;
   end

   // Handshake and next-state. A DONE result being taken frees the unit
   // in the same cycle, so back-to-back requests see no bubble.
   always_comb begin
      next_state = state;
      in_ready   = (state == IDLE) || (state == DONE && bus.out_ready);
      accept     = bus.in_valid && in_ready;
      case (state)
         IDLE: if (accept) next_state = iter_go ? BUSY : DONE;
         BUSY: if (md_done) next_state = DONE;
         DONE: begin
            if (accept) begin
               next_state = iter_go ? BUSY : DONE;
            end else if (bus.out_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // State register; reset wins over any accept or result handoff.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Opcode and sign flags remembered for the engine's final sign fix-up.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q  <= OP_ADD;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (accept) begin
         op_q  <= op_in;
         q_neg <= bus.a[XLEN-1] ^ bus.b[XLEN-1];
         r_neg <= bus.a[XLEN-1];
      end
   end

   // Select the engine output for the captured opcode and restore signs.
   always_comb begin
      iter_res = md_lo;
      case (op_q)
         OP_MUL:   iter_res = md_lo;
         OP_MULHU: iter_res = md_hi;
         OP_DIVU:  iter_res = md_lo;
         OP_REMU:  iter_res = md_hi;
         OP_DIV:   iter_res = q_neg ? -md_lo : md_lo;
         OP_REM:   iter_res = r_neg ? -md_hi : md_hi;
         default:  iter_res = md_lo;
      endcase
   end

   // Result register: loaded on a single-cycle accept or on the engine's
   // last step, otherwise held so y/Zero stay stable while stalled in DONE.
   always_ff @(posedge clk) begin
      if (reset) begin
         y_q    <= '0;
         zero_q <= 1'b1;
      end else if (accept && !iter_go) begin
         y_q    <= fast_res;
         zero_q <= (fast_res == '0);
      end else if (state == BUSY && md_done) begin
         y_q    <= iter_res;
         zero_q <= (iter_res == '0);
      end
   end

   muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (accept && iter_go),
      .op     (md_op),
      .opa    (md_op == MD_MUL ? bus.a : mag_a),
      .opb    (md_op == MD_MUL ? bus.b : mag_b),
      .done   (md_done),
      .res_hi (md_hi),
      .res_lo (md_lo)
   );

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = (state == DONE);
   assign bus.y         = y_q;
   assign bus.Zero      = zero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb_alu_multicycle: directed-vector bench for alu_multicycle (XLEN=32).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_alu_multicycle;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   errors = 0;
   int   checks = 0;

   alu_multicycle_if #(.XLEN(32)) bus ();

   alu_multicycle #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // 100 MHz-style free-running clock
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation
   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Present one request, wait for accept, then count falling edges until out_valid
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] av,
                                input logic [31:0] bv, output int lat,
                                output logic ready_in_busy);
      bus.ALUControl = op;
      bus.a          = av;
      bus.b          = bv;
      bus.in_valid   = 1'b1;
      bus.out_ready  = 1'b0;
      lat            = 0;
      ready_in_busy  = 1'b0;
      for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.out_valid && bus.in_ready) ready_in_busy = 1'b1;
      end while (!bus.out_valid && lat < 100);
   endtask

   // Hand the pending result to the consumer and return to IDLE
   task automatic releaseResult();
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.out_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_y,
                        input logic exp_zero, input int exp_lat);
      int   lat;
      logic rdy;
      applyStimulus(op, av, bv, lat, rdy);
      checkOutput({tag, ".y"}, bus.y, exp_y);
      checkOutput({tag, ".Zero"}, {31'd0, bus.Zero}, {31'd0, exp_zero});
      checkOutput({tag, ".latency"}, lat, exp_lat);
      if (exp_lat > 1) checkOutput({tag, ".in_ready_busy"}, {31'd0, rdy}, 32'd0);
      releaseResult();
   endtask

   // Safety net so the bench always ends
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int   lat;
      logic rdy;
      logic saw_valid;

      bus.in_valid   = 1'b0;
      bus.out_ready  = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.ALUControl = 4'b0000;

      repeat (3) @(negedge clk);
      checkOutput("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("reset.in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("reset.y", bus.y, 32'd0);
      checkOutput("reset.Zero", {31'd0, bus.Zero}, 32'd1);
      reset = 1'b0;
      @(negedge clk);

      $display("[TB] simple ops");
      runOp("add",  4'b0000, 32'd5,        32'd7, 32'h0000000C, 1'b0, 1);
      runOp("sub",  4'b0001, 32'd3,        32'd3, 32'h00000000, 1'b1, 1);
      runOp("slt",  4'b0101, 32'hFFFFFFFF, 32'd1, 32'h00000001, 1'b0, 1);
      runOp("sltu", 4'b0110, 32'hFFFFFFFF, 32'd1, 32'h00000000, 1'b1, 1);
      runOp("xor",  4'b0100, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'hFF005A5A, 1'b0, 1);
      runOp("and",  4'b0010, 32'hF0F0A5A5, 32'h0FF0FFFF, 32'h00F0A5A5, 1'b0, 1);
      runOp("or",   4'b0011, 32'hF0F00000, 32'h0000000F, 32'hF0F0000F, 1'b0, 1);
      runOp("sll",  4'b0111, 32'h00000003, 32'h00000024, 32'h00000030, 1'b0, 1);
      runOp("srl",  4'b1000, 32'h80000000, 32'd31,       32'h00000001, 1'b0, 1);

      $display("[TB] iterative ops");
      runOp("mul",   4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
      runOp("mulhu", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
      runOp("div",   4'b1110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, 33);
      runOp("rem",   4'b1111, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, 33);
      runOp("divu",  4'b1100, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      runOp("remu",  4'b1101, 32'd100, 32'd7, 32'd2,  1'b0, 33);

      $display("[TB] divide special cases");
      runOp("divu0", 4'b1100, 32'd10, 32'd0, 32'hFFFFFFFF, 1'b0, 1);
      runOp("rem0",  4'b1111, 32'd10, 32'd0, 32'h0000000A, 1'b0, 1);
      runOp("divov", 4'b1110, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
      runOp("remov", 4'b1111, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1);

      $display("[TB] stall in DONE then back-to-back accept");
      applyStimulus(4'b0000, 32'd2, 32'd3, lat, rdy);
      checkOutput("stall.latency", lat, 32'd1);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall.y", bus.y, 32'd5);
         checkOutput("stall.flags", {29'd0, bus.out_valid, bus.in_ready, bus.Zero}, 32'b100);
         @(negedge clk);
      end
      bus.out_ready  = 1'b1;
      bus.in_valid   = 1'b1;
      bus.ALUControl = 4'b1001;
      bus.a          = 32'h80000000;
      bus.b          = 32'd4;
      #1 checkOutput("b2b.in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(posedge clk);
      #1 begin
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b0;
      end
      @(negedge clk);
      checkOutput("b2b.out_valid", {31'd0, bus.out_valid}, 32'd1);
      checkOutput("b2b.sra.y", bus.y, 32'hF8000000);
      releaseResult();

      $display("[TB] reset during BUSY");
      bus.ALUControl = 4'b1110;
      bus.a          = 32'd100;
      bus.b          = 32'd7;
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      checkOutput("abort.busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort.out_valid", {31'd0, bus.out_valid}, 32'd0);
      checkOutput("abort.in_ready", {31'd0, bus.in_ready}, 32'd1);
      checkOutput("abort.y", bus.y, 32'd0);
      saw_valid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.out_valid) saw_valid = 1'b1;
      end
      checkOutput("abort.no_stale", {31'd0, saw_valid}, 32'd0);
      runOp("post_add", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_multicycle.md
Name: alu_multicycle

Overview:
- Parametrised XLEN-wide execution unit for the RV32I core, successor to the single-cycle ALU.
- Adds XOR, SLTU, shifts and RV32M multiply/divide/remainder.
- Simple ops complete in 1 cycle; MUL/MULHU/DIV/DIVU/REM/REMU run iteratively.
- Sits between decode and writeback behind a valid/ready handshake, so the core can stall on long ops.

Parameters:
- XLEN, 32, operand/result width; power of 2, ≥8.
- SHW, $clog2(XLEN), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept the request this cycle.
- a  in  XLEN  operand A.
- b  in  XLEN  operand B.
- ALUControl  in  4  opcode (encoding below).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result this cycle.
- y  out  XLEN  registered result.
- Zero  out  1  registered, (y == 0).

Behaviour:
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA (shift by b[SHW-1:0]).
  - 1010 MUL (low XLEN of a*b), 1011 MULHU (high XLEN, unsigned).
  - 1100 DIVU, 1101 REMU, 1110 DIV, 1111 REM (signed, truncate toward zero).
  - All 16 codes are defined; no X outputs.
- Reset values: state IDLE, out_valid 0, y 0, Zero 1, in_ready 1; iteration counter and internal registers 0.
- FSM states IDLE, BUSY, DONE:
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
  - Accept = in_valid && in_ready; a, b and ALUControl are captured on accept.
  - Simple op or resolved special case on accept → y/Zero registered in the same edge, go to DONE. out_valid is high the cycle after accept (latency 1).
  - Iterative op on accept → BUSY, counter = XLEN-1.
  - BUSY: one shift-add (mul) or restoring subtract (div) step per cycle.
  - BUSY exit: at counter 0, y/Zero are loaded and the FSM goes to DONE. out_valid rises XLEN+1 cycles after the accept edge (33 for XLEN=32).
  - DONE: out_valid=1, y/Zero held stable while out_ready=0.
  - DONE with out_ready=1: go to IDLE, or take a new accept in the same cycle (back-to-back, no bubble).
  - in_valid is ignored while BUSY; the requester must hold it until in_ready.
- Arithmetic: SUB/SLT/SLTU use XLEN-bit wraparound and compare. MUL/MULHU use a 2·XLEN product accumulator.
- Signed DIV/REM:
  - Operands converted to magnitudes, divided unsigned, then sign-corrected.
  - Quotient sign = a_sign ^ b_sign; remainder takes the sign of a.
- Special cases, all resolved in 1 cycle with no BUSY:
  - b==0: DIV/DIVU → all-ones; REM/REMU → a.
  - DIV with a==most-negative, b==-1: quotient = a, REM = 0.
- Reset mid-operation (any state): aborts the operation and discards the result. Next cycle: IDLE, out_valid 0, in_ready 1.
- Reset has priority over accept and out_ready.

Decomposition:
- Package alu_pkg holds:
  - alu_op_e, a 4-bit enum with the codes above.
  - alu_state_e (IDLE/BUSY/DONE).
  - function is_iterative(alu_op_e).
- Sub-module muldiv_iter:
  - Iterative XLEN-step unsigned shift-add multiplier and restoring divider sharing one counter.
  - Ports: clk, reset, start, op (mul/div), unsigned operands.
  - Outputs: done, hi/lo or quotient/remainder.
- Top level owns the FSM, handshake, simple-op datapath, sign handling and special cases.

Test Plan (XLEN=32):
1. Accept ADD a=5 b=7 → out_valid next cycle, y=0x0000000C, Zero=0. Then SUB a=3 b=3 → y=0, Zero=1. Then SLT a=0xFFFFFFFF b=1 → y=1; SLTU with the same operands → y=0.
2. MUL a=b=0xFFFFFFFF → y=0x00000001. MULHU with the same operands → y=0xFFFFFFFE. Both: out_valid exactly 33 cycles after accept, in_ready=0 throughout BUSY.
3. DIV a=0xFFFFFFF9 (-7) b=2 → y=0xFFFFFFFD. REM with the same operands → y=0xFFFFFFFF. DIVU a=100 b=7 → 14; REMU with the same operands → 2.
4. DIVU 10/0 → 0xFFFFFFFF; REM 10/0 → 0x0000000A; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0. Each has 1-cycle latency.
5. Hold out_ready=0 for 5 cycles in DONE → y, Zero and out_valid stable, in_ready=0. Then out_ready=1 together with in_valid (SRA a=0x80000000 b=4) → accepted that cycle; next y=0xF8000000.
6. Assert reset on the 10th BUSY cycle of a DIV → next cycle out_valid=0, in_ready=1, no stale result. A following ADD 1+1 → y=2 with 1-cycle latency.
